uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte sources (req/ack per port).
// Latency: req sampled in ARB_IDLE at edge k -> uart_transmit/ack pulse in cycle k+1.
// Backpressure: no grant while uart_is_transmitting is high; requesters hold req/byte until ack.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/byte0/ack0          port 0 request, data byte, one-cycle launch ack
//   req1/byte1/ack1          port 1 request, data byte, one-cycle launch ack
//   uart_transmit            one-cycle launch pulse to uart.transmit
//   uart_tx_byte             registered byte to uart.tx_byte
//   uart_is_transmitting     uart.is_transmitting
//   busy                     high whenever the FSM is not in ARB_IDLE
//   last_grant               index of the most recently granted port
//   timeout_err              one-cycle pulse when the UART never started a launched byte
//
// Build option: define UART_ARB_RR_EN for round-robin arbitration; otherwise port 0
// has fixed priority and last_grant is status only.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] byte0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] byte1,
  output logic       ack1,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_transmitting,
  output logic       busy,
  output logic       last_grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_LAUNCH     = 2'd1,
    ARB_WAIT_START = 2'd2,
    ARB_WAIT_DONE  = 2'd3
  } arb_state_t;

  arb_state_t state;
  logic [7:0] start_cnt;
  logic       grant_sel;

  // Winner selection; only consulted in ARB_IDLE when at least one req is high.
  always_comb begin
    grant_sel = 1'b0;
`ifdef UART_ARB_RR_EN
    if (req0 && req1) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = ~req0;
    end
`else
    grant_sel = ~req0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      uart_tx_byte <= 8'h00;
      last_grant   <= 1'b1;  // port 0 wins the first contested grant
      start_cnt    <= 8'h00;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (!uart_is_transmitting && (req0 || req1)) begin
            uart_tx_byte <= grant_sel ? byte1 : byte0;
            last_grant   <= grant_sel;
            state        <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          start_cnt <= 8'(START_TIMEOUT);
          state     <= ARB_WAIT_START;
        end
        ARB_WAIT_START: begin
          if (uart_is_transmitting) begin
            state <= ARB_WAIT_DONE;
          end else if (start_cnt == 8'h00) begin
            // Byte is dropped: no retry and no second ack.
            state <= ARB_IDLE;
          end else begin
            start_cnt <= start_cnt - 8'd1;
          end
        end
        ARB_WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Launch pulse and acks come straight from the state register; last_grant
  // was loaded on the same edge that entered ARB_LAUNCH, so it names the winner.
  assign uart_transmit = (state == ARB_LAUNCH);
  assign ack0          = (state == ARB_LAUNCH) && !last_grant;
  assign ack1          = (state == ARB_LAUNCH) &&  last_grant;
  assign busy          = (state != ARB_IDLE);

  // The watchdog fires in the ARB_WAIT_START cycle where the counter has run out,
  // unless the UART starts in that very cycle (start takes precedence).
  assign timeout_err   = (state == ARB_WAIT_START) && (start_cnt == 8'h00) &&
                         !uart_is_transmitting;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int FRAME = 6;  // model UART frame length in cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] byte0, byte1;
  logic       ack0, ack1;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_transmitting;
  logic       busy, last_grant, timeout_err;

  logic model_tx;
  logic force_busy = 1'b0;
  logic model_en   = 1'b1;
  int   frame_cnt;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  uart_tx_arbiter #(.START_TIMEOUT(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req0                 (req0),
    .byte0                (byte0),
    .ack0                 (ack0),
    .req1                 (req1),
    .byte1                (byte1),
    .ack1                 (ack1),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .busy                 (busy),
    .last_grant           (last_grant),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: is_transmitting high for FRAME cycles starting the cycle after transmit.
  always @(posedge clk) begin
    if (rst) begin
      model_tx  <= 1'b0;
      frame_cnt <= 0;
    end else if (model_tx) begin
      if (frame_cnt == 0) model_tx <= 1'b0;
      else frame_cnt <= frame_cnt - 1;
    end else if (model_en && uart_transmit) begin
      model_tx  <= 1'b1;
      frame_cnt <= FRAME - 1;
    end
  end

  assign uart_is_transmitting = model_tx | force_busy;

  // Monitor: every launch pops the next expected {port, byte}.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_transmit) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected: got ack0=%b ack1=%b byte=%02h, required no launch",
                   ack0, ack1, uart_tx_byte);
        end else begin
          mon_e = exp_q.pop_front();
          if (!(ack0 ^ ack1) || (ack1 !== mon_e.port) || (uart_tx_byte !== mon_e.data)) begin
            errors++;
            $display("FAIL launch: got ack0=%b ack1=%b byte=%02h, required port %0d byte %02h",
                     ack0, ack1, uart_tx_byte, mon_e.port, mon_e.data);
          end
        end
      end else if (ack0 || ack1) begin
        checks++;
        errors++;
        $display("FAIL ack_without_transmit: got ack0=%b ack1=%b, required 0 0", ack0, ack1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic p, input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_launch(input string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_transmit) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL %s: got no launch in 200 cycles, required a launch", name);
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !uart_is_transmitting) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int t, t1, t2, t3, to_cnt, to_at, ack_cnt, n_tx, c0, c1;
    logic seen;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; byte0 = 8'h00; byte1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_transmit", 32'(uart_transmit), 32'd0);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_tx_byte", 32'(uart_tx_byte), 32'h00);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single request on port 0
    @(posedge clk); #1 req0 = 1'b1; byte0 = 8'hA5;
    push(1'b0, 8'hA5);
    wait_launch("single_launch", t);
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    chk("single_is_tx_k2", 32'(uart_is_transmitting), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_hold_byte", 32'(uart_tx_byte), 32'hA5);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!uart_is_transmitting) begin
        seen = 1'b1;
        chk("single_busy_at_fall", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_busy_release", 32'(busy), 32'd0);
        break;
      end
    end
    chk("single_frame_end", 32'(seen), 32'd1);

    // Start watchdog: UART never responds
    @(posedge clk); #1 model_en = 1'b0; req0 = 1'b1; byte0 = 8'h77;
    push(1'b0, 8'h77);
    wait_launch("timeout_launch", t);
    @(posedge clk); #1 req0 = 1'b0;
    to_cnt = 0; to_at = -1; ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        to_cnt++;
        if (to_at < 0) to_at = cyc - t;
      end
      if (ack0 || ack1) ack_cnt++;
    end
    chk("timeout_count", 32'(to_cnt), 32'd1);
    chk("timeout_offset", 32'(to_at), 32'd5);
    chk("timeout_no_second_ack", 32'(ack_cnt), 32'd0);
    chk("timeout_idle", 32'(busy), 32'd0);
    model_en = 1'b1;

    // UART busy when req1 rises
    @(posedge clk); #1 force_busy = 1'b1; req1 = 1'b1; byte1 = 8'h3C;
    push(1'b1, 8'h3C);
    n_tx = 0;
    repeat (5) begin
      @(negedge clk);
      if (uart_transmit) n_tx++;
    end
    chk("busy_hold_off", 32'(n_tx), 32'd0);
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    chk("busy_fall_cycle_no_launch", 32'(uart_transmit), 32'd0);
    @(negedge clk);
    chk("busy_launch_after_fall", 32'(uart_transmit), 32'd1);
    @(posedge clk); #1 req1 = 1'b0;
    wait_idle("busy_idle");

    // Reset in ARB_WAIT_DONE
    @(posedge clk); #1 req0 = 1'b1; byte0 = 8'h5A;
    push(1'b0, 8'h5A);
    wait_launch("rstmid_launch", t);
    @(posedge clk); #1 req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    chk("rstmid_grant_before", 32'(last_grant), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_transmit", 32'(uart_transmit), 32'd0);
    chk("rstmid_last_grant", 32'(last_grant), 32'd1);
    chk("rstmid_tx_byte", 32'(uart_tx_byte), 32'h00);
    chk("rstmid_no_pulses", 32'({ack1, ack0, timeout_err}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Contention: both ports held for 4 bytes each
    @(posedge clk); #1 req0 = 1'b1; req1 = 1'b1; byte0 = 8'h11; byte1 = 8'h22;
`ifdef UART_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 8'h11);
      push(1'b1, 8'h22);
    end
`else
    for (int i = 0; i < 4; i++) push(1'b0, 8'h11);
    for (int i = 0; i < 4; i++) push(1'b1, 8'h22);
`endif
    c0 = 0; c1 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack0) c0++;
      if (ack1) c1++;
      if (c0 == 4) req0 = 1'b0;
      if (c1 == 4) req1 = 1'b0;
      if (c0 == 4 && c1 == 4) break;
    end
    chk("contend_acks0", 32'(c0), 32'd4);
    chk("contend_acks1", 32'(c1), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("contend_idle");

    // Back-to-back held request: launch period = frame + 3 cycles
    @(posedge clk); #1 req0 = 1'b1; byte0 = 8'hC3;
    for (int i = 0; i < 3; i++) push(1'b0, 8'hC3);
    wait_launch("b2b_launch1", t1);
    wait_launch("b2b_launch2", t2);
    wait_launch("b2b_launch3", t3);
    req0 = 1'b0;
    chk("b2b_gap12", 32'(t2 - t1), 32'(FRAME + 3));
    chk("b2b_gap23", 32'(t3 - t2), 32'(FRAME + 3));
    wait_idle("b2b_idle");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
